// File: rtl/systolic_pkg.sv
// Shared state encoding, default widths and the row-major index helper
// used by the systolic array sequencer and its edge-feed selector.
package systolic_pkg;

    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_ACC_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN
    } sched_state_t;

    function automatic int idx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

endpackage

// File: rtl/systolic_skew_feed.sv
// Combinational edge-operand selection: row i gets A[i][t-i], column j gets
// B[t-j][j], zero outside the diagonal wavefront. The parent registers the result.
module systolic_skew_feed
    import systolic_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = DEFAULT_DW,
    parameter int CW = 3
) (
    input  logic [2*N*N*DW-1:0] opbuf_i,
    input  logic [CW-1:0]       t_i,
    output logic [N*DW-1:0]     a_edge_o,
    output logic [N*DW-1:0]     b_edge_o
);

    // Operand buffer layout: A row-major in slots 0..N*N-1, B row-major after it.
    for (genvar gi = 0; gi < N; gi++) begin : g_edge
        logic [DW-1:0] a_sel;
        logic [DW-1:0] b_sel;

        always_comb begin
            a_sel = '0;
            b_sel = '0;
            for (int k = 0; k < N; k++) begin
                if (t_i == CW'(gi + k)) begin
                    a_sel = opbuf_i[idx(gi, k, N)*DW +: DW];
                    b_sel = opbuf_i[(N*N + idx(k, gi, N))*DW +: DW];
                end
            end
        end

        assign a_edge_o[gi*DW +: DW] = a_sel;
        assign b_edge_o[gi*DW +: DW] = b_sel;
    end

endmodule

// File: rtl/systolic_sched.sv
// Load / clear / skewed-feed / flush / drain sequencer for an NxN output-stationary
// PE array. Define SYSTOLIC_SCHED_RELU_EN to clamp negative results to zero on drain.
module systolic_sched
    import systolic_pkg::*;
#(
    parameter int N     = 2,
    parameter int DW    = DEFAULT_DW,
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [DW-1:0]          in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic [N*DW-1:0]        pe_a,
    output logic [N*DW-1:0]        pe_b,
    output logic                   pe_en,
    output logic                   pe_clr,
    output logic [$clog2(N*N)-1:0] pe_sel,
    input  logic [ACC_W-1:0]       pe_acc
);

    localparam int BUF_N = 2 * N * N;
    localparam int SW    = $clog2(N * N);
    // One counter serves load bytes, feed steps, flush steps and drain bytes.
    localparam int CW    = SW + 1;

    sched_state_t        state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                wr_en;
    logic [DW-1:0]       opbuf_q [BUF_N];
    logic [BUF_N*DW-1:0] opbuf_flat;
    logic [N*DW-1:0]     a_edge, b_edge;
    logic [N*DW-1:0]     pe_a_q, pe_b_q;
    logic                pe_en_q, pe_clr_q;
    logic [SW-1:0]       pe_sel_q;
    logic [ACC_W-1:0]    acc_eff;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        wr_en   = 1'b1;
                        state_d = S_LOAD;
                        cnt_d   = CW'(1);
                    end
                end
                S_LOAD: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        wr_en = 1'b1;
                        if (cnt_q == CW'(BUF_N - 1)) begin
                            state_d = S_CLEAR;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                S_CLEAR: begin
                    state_d = S_FEED;
                    cnt_d   = '0;
                end
                S_FEED: begin
                    if (cnt_q == CW'(2 * N - 2)) begin
                        state_d = S_FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        if (cnt_q == CW'(BUF_N - 1)) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Operand storage is deliberately not reset; every job overwrites all slots.
    always_ff @(posedge clk) begin
        if (ena && wr_en) begin
            for (int i = 0; i < BUF_N; i++) begin
                if (cnt_q == CW'(i)) opbuf_q[i] <= in_data;
            end
        end
    end

    for (genvar gi = 0; gi < BUF_N; gi++) begin : g_flat
        assign opbuf_flat[gi*DW +: DW] = opbuf_q[gi];
    end

    // Edges are selected from the next feed step so the registered value lines up
    // with the cycle in which that step is active.
    systolic_skew_feed #(
        .N  (N),
        .DW (DW),
        .CW (CW)
    ) u_skew (
        .opbuf_i  (opbuf_flat),
        .t_i      (cnt_d),
        .a_edge_o (a_edge),
        .b_edge_o (b_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            pe_a_q   <= '0;
            pe_b_q   <= '0;
            pe_en_q  <= 1'b0;
            pe_clr_q <= 1'b0;
            pe_sel_q <= '0;
        end else if (ena) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            pe_clr_q <= (state_d == S_CLEAR);
            pe_en_q  <= (state_d == S_FEED) || (state_d == S_FLUSH);
            pe_a_q   <= (state_d == S_FEED) ? a_edge : '0;
            pe_b_q   <= (state_d == S_FEED) ? b_edge : '0;
            pe_sel_q <= (state_d == S_DRAIN) ? cnt_d[SW:1] : '0;
        end
    end

`ifdef SYSTOLIC_SCHED_RELU_EN
    assign acc_eff = pe_acc[ACC_W-1] ? '0 : pe_acc;
`else
    assign acc_eff = pe_acc;
`endif

    // Even drain counts carry the low byte of result cnt/2, odd counts the high byte.
    assign out_data = (state_q == S_DRAIN) ? (cnt_q[0] ? acc_eff[ACC_W-1 -: 8] : acc_eff[7:0])
                                           : 8'h00;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign pe_a     = pe_a_q;
    assign pe_b     = pe_b_q;
    assign pe_en    = pe_en_q;
    assign pe_clr   = pe_clr_q;
    assign pe_sel   = pe_sel_q;

endmodule

// File: tb/tb_systolic_sched.sv
// Randomized scoreboard bench for systolic_sched: a behavioural PE array answers pe_acc,
// and expected result bytes come from a plain matrix product pushed when a job is issued.
module tb_systolic_sched;

    localparam int N     = 2;
    localparam int DW    = 8;
    localparam int ACC_W = 16;
    localparam int BUF_N = 2 * N * N;
    localparam int SW    = $clog2(N * N);
    localparam int LAT   = 2 * N * N + 1 + (2 * N - 1) + N;

    typedef int mat_t [N][N];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b1;
    logic [DW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy, done;
    logic [N*DW-1:0]   pe_a, pe_b;
    logic              pe_en, pe_clr;
    logic [SW-1:0]     pe_sel;
    logic [ACC_W-1:0]  pe_acc;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    bit  ena_rand = 0;
    int  ordy_mode = 0;
    bit  lat_chk = 0;
    int  job_id = 0;

    systolic_sched #(.N(N), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done),
        .pe_a(pe_a), .pe_b(pe_b), .pe_en(pe_en), .pe_clr(pe_clr),
        .pe_sel(pe_sel), .pe_acc(pe_acc)
    );

    always #5 clk = ~clk;

    // Behavioural output-stationary array: operands enter at the edges and shift right/down.
    logic signed [DW-1:0]    a_r [N][N];
    logic signed [DW-1:0]    b_r [N][N];
    logic signed [ACC_W-1:0] acc [N][N];

    always @(posedge clk) begin
        if (ena && pe_clr) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0; a_r[i][j] <= '0; b_r[i][j] <= '0;
                end
        end else if (ena && pe_en) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    logic signed [DW-1:0] ain, bin;
                    ain = (j == 0) ? $signed(pe_a[i*DW +: DW]) : a_r[i][j-1];
                    bin = (i == 0) ? $signed(pe_b[j*DW +: DW]) : b_r[i-1][j];
                    acc[i][j] <= acc[i][j] + ain * bin;
                    a_r[i][j] <= ain;
                    b_r[i][j] <= bin;
                end
        end
    end

    assign pe_acc = acc[int'(pe_sel) / N][int'(pe_sel) % N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_expected(input mat_t a, input mat_t b);
        for (int r = 0; r < N * N; r++) begin
            int s;
            logic [15:0] v;
            s = 0;
            for (int k = 0; k < N; k++) s += a[r / N][k] * b[k][r % N];
            v = 16'(s);
`ifdef SYSTOLIC_SCHED_RELU_EN
            if (v[15]) v = '0;
`endif
            exp_q.push_back(v[7:0]);
            exp_q.push_back(v[15:8]);
        end
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m[i][j] = int'($signed(8'($urandom)));
        return m;
    endfunction

    task automatic send_job(input mat_t a, input mat_t b, input int gap_pct, input bit keep_valid);
        logic [DW-1:0] bytes [BUF_N];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                bytes[i*N + j]       = DW'(a[i][j]);
                bytes[N*N + i*N + j] = DW'(b[i][j]);
            end
        push_expected(a, b);
        $display("job %0d issued: A00=%0d B00=%0d gap=%0d", job_id, a[0][0], b[0][0], gap_pct);
        job_id++;
        for (int n = 0; n < BUF_N; n++) begin
            bit got;
            int w;
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = bytes[n];
            got = 0;
            w = 0;
            while (!got && w < 300) begin
                @(negedge clk);
                got = in_ready;
                @(posedge clk); #1;
                w++;
            end
            check("in_accept", got, 1);
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_pe_clr();
        int n = 0;
        do begin @(negedge clk); n++; end while (!pe_clr && n < 200);
        check("pe_clr_seen", pe_clr, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy || done || exp_q.size() != 0) && n < 3000);
        check("job_complete", {busy, exp_q.size() != 0}, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pe_a"}, pe_a, 0);
        check({tag, "_pe_b"}, pe_b, 0);
        check({tag, "_pe_en"}, pe_en, 0);
        check({tag, "_pe_clr"}, pe_clr, 0);
        check({tag, "_pe_sel"}, pe_sel, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    // Handshake drivers, updated just after each rising edge.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            ena = ena_rand ? ($urandom_range(9) != 0) : 1'b1;
            case (ordy_mode)
                0: out_ready = 1'b1;
                1: begin ph = (ph + 1) % 3; out_ready = (ph == 0); end
                default: out_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // Monitor: pops expected bytes on each accepted output byte and checks side rules.
    int         cyc = 0, load_cnt = 0, jobs_done = 0, job_byte = 0, t_first = 0;
    bit         done_exp = 0, final_prev = 0, ena_prev = 0, prev_stall = 0, first_out_seen = 0;
    logic [7:0] prev_data = '0;

    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                load_cnt = 0; jobs_done = 0; job_byte = 0;
                done_exp = 0; final_prev = 0; ena_prev = 0; prev_stall = 0; first_out_seen = 0;
            end else begin
                bit hs_final;
                hs_final = 0;
                cyc++;
                if (ena_prev) done_exp = final_prev;
                check("done", done, done_exp);
                if (done_exp) check("busy_after_done", busy, 0);
                if (!ena) begin
                    check("in_ready_ena0", in_ready, 0);
                    check("out_valid_ena0", out_valid, 0);
                end
                if (pe_en || pe_clr || out_valid) check("in_ready_busy", in_ready, 0);
                if (in_valid && in_ready) begin
                    if (load_cnt % BUF_N == 0) t_first = cyc;
                    load_cnt++;
                end
                if (out_valid) begin
                    check("load_count", load_cnt, (jobs_done + 1) * BUF_N);
                    if (!first_out_seen) begin
                        first_out_seen = 1;
                        if (lat_chk) check("latency", cyc - t_first, LAT);
                    end
                    if (prev_stall) check("stall_hold", out_data, prev_data);
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("extra_byte", out_valid, 0);
                        end else begin
                            logic [7:0] eb;
                            eb = exp_q.pop_front();
                            $display("out byte %0d: got=%02h exp=%02h", job_byte, out_data, eb);
                            check("out_byte", out_data, eb);
                        end
                        hs_final = (job_byte == BUF_N - 1);
                        job_byte = hs_final ? 0 : job_byte + 1;
                        if (hs_final) begin
                            jobs_done++;
                            first_out_seen = 0;
                        end
                    end
                end
                final_prev = hs_final;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                ena_prev   = ena;
            end
        end
    end

    initial begin
        mat_t a1, b1, a2, b2, ar, br;
        a1 = '{'{1, 2}, '{3, 4}};
        b1 = '{'{5, 6}, '{7, 8}};
        a2 = '{'{-1, 0}, '{0, 1}};
        b2 = '{'{1, 0}, '{0, 1}};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Directed job: latency and skewed edge pattern.
        lat_chk = 1;
        send_job(a1, b1, 0, 0);
        wait_pe_clr();
        @(negedge clk);
        check("feed0_en", pe_en, 1);
        check("feed0_a", pe_a, 16'h0001);
        check("feed0_b", pe_b, 16'h0005);
        @(negedge clk);
        check("feed1_a", pe_a, 16'h0302);
        check("feed1_b", pe_b, 16'h0607);
        @(negedge clk);
        check("feed2_a", pe_a, 16'h0400);
        check("feed2_b", pe_b, 16'h0800);
        wait_idle();
        lat_chk = 0;

        // Negative result with out_ready high one cycle in three.
        ordy_mode = 1;
        send_job(a2, b2, 0, 0);
        wait_idle();
        ordy_mode = 0;

        // Back-to-back jobs with in_valid held high through CLEAR..DRAIN.
        ar = rand_mat(); br = rand_mat();
        send_job(ar, br, 0, 1);
        ar = rand_mat(); br = rand_mat();
        send_job(ar, br, 0, 0);
        wait_idle();

        // Asynchronous reset during feed step t=1, then a clean job.
        ar = rand_mat(); br = rand_mat();
        send_job(ar, br, 0, 0);
        wait_pe_clr();
        @(negedge clk);
        @(negedge clk);
        check("feed1_before_reset_en", pe_en, 1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midfeed");
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_job(a1, b1, 0, 0);
        wait_idle();

        // Random jobs with input gaps, random out_ready and random clock-enable drops.
        ena_rand = 1;
        ordy_mode = 2;
        for (int j = 0; j < 8; j++) begin
            ar = rand_mat(); br = rand_mat();
            send_job(ar, br, 25, 0);
            wait_idle();
        end
        ena_rand = 0;
        ordy_mode = 0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
